// File: rtl/ysyx_220053_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, the NOP
// word delivered on a faulting fetch, and default address parameters.
package ysyx_220053_ifu_pkg;

  localparam int unsigned AW_DEF       = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  // REQ: issue fetch, WAIT: response outstanding, OUT: offer (pc, inst),
  // NPC: delivered, waiting for execute to report the next pc.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2,
    ST_NPC  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_220053_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, the
// (pc, inst) hand-off to execute, and the next-pc / redirect return path.
interface ysyx_220053_ifu_if
  import ysyx_220053_ifu_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
);
  logic          imem_req_v;
  logic          imem_req_rdy;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_v;
  logic [31:0]   imem_rdata;
  logic          imem_err;
  logic          out_v;
  logic          out_rdy;
  logic [AW-1:0] out_pc;
  logic [31:0]   out_inst;
  logic          out_exc;
  logic          npc_v;
  logic [AW-1:0] npc;
  logic          flush_v;
  logic [AW-1:0] flush_pc;

  // Fetch unit side.
  modport master (
    output imem_req_v, imem_addr, out_v, out_pc, out_inst, out_exc,
    input  imem_req_rdy, imem_rsp_v, imem_rdata, imem_err,
           out_rdy, npc_v, npc, flush_v, flush_pc
  );

  // Memory / execute side.
  modport slave (
    input  imem_req_v, imem_addr, out_v, out_pc, out_inst, out_exc,
    output imem_req_rdy, imem_rsp_v, imem_rdata, imem_err,
           out_rdy, npc_v, npc, flush_v, flush_pc
  );
endinterface

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit. One memory read in flight at most; each fetched
// word is handed to execute, then the unit waits for that instruction's
// next pc. A redirect overrides the pc in any state; a response belonging
// to a request made before the redirect is dropped via the stale flag, and
// no new request is issued until that response has drained.
module ysyx_220053_ifu
  import ysyx_220053_ifu_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter logic [AW-1:0] RESET_PC = RESET_PC_DEF
) (
  input logic                clk,
  input logic                rst,
  ysyx_220053_ifu_if.master  bus
);

  ifu_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          stale_q, stale_d;
  logic          run_q;
  logic [AW-1:0] out_pc_q;
  logic [31:0]   out_inst_q;
  logic          out_exc_q;

  logic          req_v;
  logic          req_fire;
  logic          cap;
  logic [31:0]   cap_inst;
  logic          cap_exc;

  // run_q holds the request off until the first clock after reset release.
  assign req_v    = run_q && (state_q == ST_REQ) && !pc_q[1] && !stale_q;
  assign req_fire = req_v && bus.imem_req_rdy;

  assign bus.imem_req_v = req_v;
  assign bus.imem_addr  = pc_q;
  assign bus.out_v      = (state_q == ST_OUT);
  assign bus.out_pc     = out_pc_q;
  assign bus.out_inst   = out_inst_q;
  assign bus.out_exc    = out_exc_q;

  // Next state, next pc, stale tracking and capture of the delivered word.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d  = state_q;
    pc_d     = pc_q;
    stale_d  = stale_q && !bus.imem_rsp_v;
    cap      = 1'b0;
    cap_inst = NOP;
    cap_exc  = 1'b0;

    if (bus.flush_v) begin
      state_d = ST_REQ;
      pc_d    = bus.flush_pc;
      // A request is (or is about to be) outstanding with no response this
      // cycle: its response must be thrown away when it arrives.
      if ((state_q == ST_WAIT && !bus.imem_rsp_v) || req_fire) begin
        stale_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (run_q && pc_q[1]) begin
            cap     = 1'b1;
            cap_exc = 1'b1;
            state_d = ST_OUT;
          end else if (req_fire) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_v && !stale_q) begin
            cap      = 1'b1;
            cap_exc  = bus.imem_err;
            cap_inst = bus.imem_err ? NOP : bus.imem_rdata;
            state_d  = ST_OUT;
          end else if (bus.imem_rsp_v) begin
            state_d = ST_REQ;
          end
        end
        ST_OUT: begin
          if (bus.out_rdy) begin
            if (bus.npc_v) begin
              pc_d    = bus.npc;
              state_d = ST_REQ;
            end else begin
              state_d = ST_NPC;
            end
          end
        end
        ST_NPC: begin
          if (bus.npc_v) begin
            pc_d    = bus.npc;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // State, pc and the delivered-instruction holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      stale_q    <= 1'b0;
      run_q      <= 1'b0;
      out_pc_q   <= RESET_PC;
      out_inst_q <= '0;
      out_exc_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      run_q   <= 1'b1;
      if (cap) begin
        out_pc_q   <= pc_q;
        out_inst_q <= cap_inst;
        out_exc_q  <= cap_exc;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Self-checking bench for ysyx_220053_ifu: directed reset/stall/flush
// sequences, a table of single fetches, and a randomized run checked
// against a transaction-level model of the fetch stream.
module tb_ysyx_220053_ifu;
  import ysyx_220053_ifu_pkg::*;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_220053_ifu_if #(.AW(64)) bus ();

  ysyx_220053_ifu #(.AW(64), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] npc;
    logic [31:0] rdata;
    logic        err;
    logic        exp_req;
    logic [31:0] exp_inst;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.imem_req_rdy = 1'b0;
    bus.imem_rsp_v   = 1'b0;
    bus.imem_rdata   = '0;
    bus.imem_err     = 1'b0;
    bus.out_rdy      = 1'b0;
    bus.npc_v        = 1'b0;
    bus.npc          = '0;
    bus.flush_v      = 1'b0;
    bus.flush_pc     = '0;
  endtask

  // Bounded wait for out_v (sel_out=1) or imem_req_v (sel_out=0).
  task automatic wait_sig(input string name, input bit sel_out, input int budget);
    int n;
    n = 0;
    while (((sel_out ? bus.out_v : bus.imem_req_v) !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    check({name, "_timeout"}, {63'd0, ((sel_out ? bus.out_v : bus.imem_req_v) === 1'b1)}, 64'd1);
  endtask

  // Memory contents for the random run: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] ^ 32'h5A5A_0000) * 32'h9E37_79B1;
  endfunction

  function automatic logic mem_err(input logic [63:0] a);
    return (a[9:2] % 8'd29) == 8'd0;
  endfunction

  function automatic logic [63:0] rand_pc();
    if (($urandom % 16) == 0) return RPC + 64'd2 + 64'(4 * ($urandom % 64));
    return RPC + 64'(4 * ($urandom % 256));
  endfunction

  function automatic logic [63:0] next_pc(input logic [63:0] t);
    if (t[1] || ($urandom % 8) == 0) return rand_pc();
    return t + 64'd4;
  endfunction

  initial begin
    logic [63:0] target;
    logic [63:0] mem_addr;
    logic [63:0] owe_npc;
    logic [31:0] exp_inst;
    logic        exp_exc;
    bit          mem_busy;
    bit          owe;
    bit          imm;
    bit          late;
    int          mem_cnt;
    int          owe_cnt;
    int          delivered;
    int          n;

    vecs[0] = '{64'h0000_0000_8000_0006, 32'h1111_1111, 1'b0, 1'b0, NOP,           1'b1};
    vecs[1] = '{64'h0000_0000_8000_0010, 32'h0010_0073, 1'b1, 1'b1, NOP,           1'b1};
    vecs[2] = '{64'h0000_0000_8000_0014, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_0004, 32'h0000_0513, 1'b0, 1'b1, 32'h0000_0513, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 32'h2222_2222, 1'b0, 1'b0, NOP,           1'b1};
    vecs[5] = '{64'h0000_0000_8000_0020, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{64'h0000_0000_8000_000A, 32'h3333_3333, 1'b1, 1'b0, NOP,           1'b1};

    // ---- reset state and first fetch ----
    idle();
    rst = 1'b0;
    repeat (3) step();
    check("rst_req_v",    bus.imem_req_v, 0);
    check("rst_out_v",    bus.out_v, 0);
    check("rst_out_exc",  bus.out_exc, 0);
    check("rst_out_inst", bus.out_inst, 0);
    check("rst_out_pc",   bus.out_pc, RPC);
    bus.imem_req_rdy = 1'b1;
    rst = 1'b1;
    #1;
    check("release_req_v_low", bus.imem_req_v, 0);
    step();
    check("first_req_v", bus.imem_req_v, 1);
    check("first_addr",  bus.imem_addr, RPC);
    step();
    bus.imem_req_rdy = 1'b0;
    bus.imem_rsp_v   = 1'b1;
    bus.imem_rdata   = 32'h0000_0297;
    step();
    bus.imem_rsp_v = 1'b0;
    check("first_out_v",    bus.out_v, 1);
    check("first_out_pc",   bus.out_pc, RPC);
    check("first_out_inst", bus.out_inst, 32'h0000_0297);
    check("first_out_exc",  bus.out_exc, 0);

    // ---- execute stalls 5 cycles, then next pc ----
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_out_v", i),    bus.out_v, 1);
      check($sformatf("stall%0d_out_pc", i),   bus.out_pc, RPC);
      check($sformatf("stall%0d_out_inst", i), bus.out_inst, 32'h0000_0297);
      step();
    end
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    check("npc_wait_out_v", bus.out_v, 0);
    check("npc_wait_req_v", bus.imem_req_v, 0);
    bus.npc_v = 1'b1;
    bus.npc   = 64'h0000_0000_8000_0004;
    step();
    bus.npc_v = 1'b0;

    // ---- memory not ready for 4 cycles ----
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold%0d_req_v", i), bus.imem_req_v, 1);
      check($sformatf("hold%0d_addr", i),  bus.imem_addr, 64'h0000_0000_8000_0004);
      step();
    end
    bus.imem_req_rdy = 1'b1;
    step();
    bus.imem_req_rdy = 1'b0;
    bus.imem_rsp_v   = 1'b1;
    bus.imem_rdata   = 32'h0000_0513;
    step();
    bus.imem_rsp_v = 1'b0;
    check("hold_out_pc",   bus.out_pc, 64'h0000_0000_8000_0004);
    check("hold_out_inst", bus.out_inst, 32'h0000_0513);

    // ---- next pc in the same cycle as the hand-off ----
    bus.out_rdy = 1'b1;
    bus.npc_v   = 1'b1;
    bus.npc     = 64'h0000_0000_8000_0008;
    step();
    bus.out_rdy = 1'b0;
    bus.npc_v   = 1'b0;
    check("imm_npc_req_v", bus.imem_req_v, 1);
    check("imm_npc_addr",  bus.imem_addr, 64'h0000_0000_8000_0008);

    // ---- flush while waiting; response arrives 2 cycles later ----
    bus.imem_req_rdy = 1'b1;
    step();
    bus.imem_req_rdy = 1'b0;
    bus.flush_v  = 1'b1;
    bus.flush_pc = 64'h0000_0000_8000_0100;
    step();
    bus.flush_v = 1'b0;
    step();
    bus.imem_rsp_v = 1'b1;
    bus.imem_rdata = 32'hBAD0_0BAD;
    step();
    bus.imem_rsp_v = 1'b0;
    check("stale_not_delivered", bus.out_v, 0);
    bus.imem_req_rdy = 1'b1;
    wait_sig("flush_req", 1'b0, 10);
    check("flush_addr", bus.imem_addr, 64'h0000_0000_8000_0100);
    step();
    bus.imem_req_rdy = 1'b0;
    bus.imem_rsp_v   = 1'b1;
    bus.imem_rdata   = 32'h0000_0117;
    step();
    bus.imem_rsp_v = 1'b0;
    check("flush_out_v",    bus.out_v, 1);
    check("flush_out_pc",   bus.out_pc, 64'h0000_0000_8000_0100);
    check("flush_out_inst", bus.out_inst, 32'h0000_0117);
    check("flush_out_exc",  bus.out_exc, 0);
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;

    // ---- table of single fetches ----
    for (int i = 0; i < 7; i++) begin
      bus.npc_v        = 1'b1;
      bus.npc          = vecs[i].npc;
      bus.imem_req_rdy = 1'b1;
      step();
      bus.npc_v = 1'b0;
      n = 0;
      while (!(bus.imem_req_v || bus.out_v) && n < 10) begin
        step();
        n++;
      end
      check($sformatf("vec%0d_req", i), bus.imem_req_v, vecs[i].exp_req);
      if (bus.imem_req_v) begin
        check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].npc);
        step();
        bus.imem_rsp_v = 1'b1;
        bus.imem_rdata = vecs[i].rdata;
        bus.imem_err   = vecs[i].err;
        step();
        bus.imem_rsp_v = 1'b0;
        bus.imem_err   = 1'b0;
      end
      wait_sig($sformatf("vec%0d_out", i), 1'b1, 10);
      check($sformatf("vec%0d_pc", i),   bus.out_pc, vecs[i].npc);
      check($sformatf("vec%0d_inst", i), bus.out_inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_exc", i),  bus.out_exc, vecs[i].exp_exc);
      bus.imem_req_rdy = 1'b0;
      bus.out_rdy      = 1'b1;
      step();
      bus.out_rdy = 1'b0;
    end

    // ---- reset asserted while a response is outstanding ----
    bus.npc_v        = 1'b1;
    bus.npc          = 64'h0000_0000_8000_0040;
    bus.imem_req_rdy = 1'b1;
    step();
    bus.npc_v = 1'b0;
    step();
    bus.imem_req_rdy = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_v",   bus.out_v, 0);
    check("midrst_req_v",   bus.imem_req_v, 0);
    check("midrst_out_pc",  bus.out_pc, RPC);
    check("midrst_out_exc", bus.out_exc, 0);
    step();
    rst = 1'b1;
    bus.imem_req_rdy = 1'b1;
    wait_sig("refetch_req", 1'b0, 10);
    check("refetch_addr", bus.imem_addr, RPC);
    step();
    bus.imem_req_rdy = 1'b0;
    bus.imem_rsp_v   = 1'b1;
    bus.imem_rdata   = 32'h0000_0297;
    step();
    bus.imem_rsp_v = 1'b0;
    check("refetch_out_pc",   bus.out_pc, RPC);
    check("refetch_out_inst", bus.out_inst, 32'h0000_0297);

    // ---- randomized run against a fetch-stream model ----
    idle();
    rst = 1'b0;
    step();
    step();
    rst       = 1'b1;
    target    = RPC;
    mem_busy  = 1'b0;
    mem_cnt   = 0;
    mem_addr  = '0;
    owe       = 1'b0;
    owe_cnt   = 0;
    owe_npc   = '0;
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.imem_req_rdy = ($urandom % 4) != 0;
      bus.imem_rsp_v   = mem_busy && mem_cnt == 0;
      bus.imem_rdata   = mem_word(mem_addr);
      bus.imem_err     = mem_err(mem_addr);
      bus.out_rdy      = ($urandom % 3) != 0;
      bus.flush_v      = ($urandom % 20) == 0;
      bus.flush_pc     = rand_pc();
      imm  = 1'b0;
      late = 1'b0;
      bus.npc_v = 1'b0;
      bus.npc   = rand_pc();
      if (owe && owe_cnt == 0) begin
        late      = 1'b1;
        bus.npc_v = 1'b1;
        bus.npc   = owe_npc;
      end else if (!owe && bus.out_v && bus.out_rdy && ($urandom % 3) == 0) begin
        imm       = 1'b1;
        bus.npc_v = 1'b1;
        bus.npc   = next_pc(target);
      end else if (!owe && !bus.out_v && ($urandom % 8) == 0) begin
        bus.npc_v = 1'b1;
      end
      #3;
      if (bus.imem_req_v) begin
        check("rnd_req_addr", bus.imem_addr, target);
        check("rnd_req_aligned", {63'd0, bus.imem_addr[1]}, 64'd0);
      end
      if (bus.imem_req_v && bus.imem_req_rdy) begin
        check("rnd_one_outstanding", {63'd0, mem_busy}, 64'd0);
      end
      if (bus.imem_rsp_v) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (bus.imem_req_v && bus.imem_req_rdy) begin
        mem_busy = 1'b1;
        mem_addr = bus.imem_addr;
        mem_cnt  = $urandom % 3;
      end
      if (bus.flush_v) begin
        target = bus.flush_pc;
        owe    = 1'b0;
      end else if (bus.out_v && bus.out_rdy) begin
        exp_exc  = target[1] || mem_err(target);
        exp_inst = exp_exc ? NOP : mem_word(target);
        check("rnd_out_pc",   bus.out_pc, target);
        check("rnd_out_inst", bus.out_inst, exp_inst);
        check("rnd_out_exc",  bus.out_exc, exp_exc);
        delivered++;
        if (imm) begin
          target = bus.npc;
        end else begin
          owe     = 1'b1;
          owe_cnt = $urandom % 4;
          owe_npc = next_pc(target);
        end
      end else if (late) begin
        target = owe_npc;
        owe    = 1'b0;
      end else if (owe) begin
        owe_cnt--;
      end
      @(posedge clk);
      #1;
    end
    check("rnd_liveness", {63'd0, delivered > 50}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
